// File: rtl/iwdg_pkg.sv
// -----------------------------------------------------------------------------
// iwdg_pkg
// Shared definitions for the IWDG Wishbone sequencer: the IWDG key values,
// register offsets relative to the IWDG base address, the sequencer state
// encoding and two small helpers describing the configure sequence order.
// -----------------------------------------------------------------------------
package iwdg_pkg;

   // Key register values understood by the IWDG.
   localparam logic [15:0] KEY_ACCESS = 16'h5555;  // unlock PR/RLR for writing
   localparam logic [15:0] KEY_RELOAD = 16'hAAAA;  // reload counter from RLR
   localparam logic [15:0] KEY_START  = 16'hCCCC;  // start the watchdog

   // Register offsets from the IWDG base address.
   localparam logic [31:0] KR_OFS  = 32'h0000_0000;
   localparam logic [31:0] PR_OFS  = 32'h0000_0004;
   localparam logic [31:0] RLR_OFS = 32'h0000_0008;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_UNLOCK,
      ST_WR_PR,
      ST_WR_RLR,
      ST_RD_RLR,
      ST_RELOAD,
      ST_START,
      ST_RUN,
      ST_KICK,
      ST_GAP
   } iwdg_state_e;

   // States in which a Wishbone transaction is outstanding.
   function automatic logic is_bus_state(input iwdg_state_e s);
      return !(s inside {ST_IDLE, ST_RUN, ST_GAP});
   endfunction

   // Where the FSM goes once the one-cycle gap after bus state s has elapsed.
   function automatic iwdg_state_e next_after(input iwdg_state_e s);
      case (s)
         ST_UNLOCK: return ST_WR_PR;
         ST_WR_PR:  return ST_WR_RLR;
         ST_WR_RLR: return ST_RD_RLR;
         ST_RD_RLR: return ST_RELOAD;
         ST_RELOAD: return ST_START;
         ST_START:  return ST_RUN;
         ST_KICK:   return ST_RUN;
         default:   return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/iwdg_wb_xfer.sv
// -----------------------------------------------------------------------------
// iwdg_wb_xfer
// Single Wishbone transaction engine. A launch pulse loads address, data and
// write enable and raises cyc/stb on the same clock edge. The request is held
// until ack_s2m is sampled or until stb has been high for TIMEOUT cycles
// without ack, whichever comes first; cyc/stb drop on that edge. The
// xfer_done / xfer_timeout strobes are combinational so the controlling FSM
// advances on the very edge the bus cycle ends. Read data is captured on ack.
//
// Ports
//   clk_m2s, rst_m2s   bus clock, asynchronous active-high reset
//   launch             start a transaction with req_adr / req_dat / req_we
//   adr_m2s .. stb_m2s registered Wishbone master outputs
//   dat_s2m, ack_s2m   Wishbone slave response
//   xfer_done          ack sampled this cycle (transaction completes)
//   xfer_timeout       final unacked cycle (transaction aborts)
//   rdata              read data captured on the last acked read
// -----------------------------------------------------------------------------
module iwdg_wb_xfer #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 16
) (
   input  logic          clk_m2s,
   input  logic          rst_m2s,
   input  logic          launch,
   input  logic [31:0]   req_adr,
   input  logic [DW-1:0] req_dat,
   input  logic          req_we,
   output logic [31:0]   adr_m2s,
   output logic [DW-1:0] dat_m2s,
   output logic          we_m2s,
   output logic          cyc_m2s,
   output logic          stb_m2s,
   input  logic [DW-1:0] dat_s2m,
   input  logic          ack_s2m,
   output logic          xfer_done,
   output logic          xfer_timeout,
   output logic [DW-1:0] rdata
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   logic          act_q,   act_d;
   logic [31:0]   adr_q,   adr_d;
   logic [DW-1:0] dat_q,   dat_d;
   logic          we_q,    we_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;

   // An ack seen while no cycle is open is simply not looked at.
   assign xfer_done    = act_q & ack_s2m;
   // Counter counts unacked stb cycles already elapsed; the cycle in which it
   // reads TIMEOUT-1 is the last one allowed.
   assign xfer_timeout = act_q & ~ack_s2m & (cnt_q == TO_LAST);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the
      // block leaves it unassigned; otherwise synthesis infers a latch.
      act_d   = act_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      if (launch) begin
         act_d = 1'b1;
         adr_d = req_adr;
         dat_d = req_dat;
         we_d  = req_we;
         cnt_d = '0;
      end else if (act_q) begin
         if (ack_s2m) begin
            act_d = 1'b0;
            if (!we_q) rdata_d = dat_s2m;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TO_LAST) act_d = 1'b0;
         end
      end
   end

   // NOTE: flops are written with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_m2s or posedge rst_m2s) begin
      if (rst_m2s) begin
         act_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         act_q   <= act_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   assign adr_m2s = adr_q;
   assign dat_m2s = dat_q;
   assign we_m2s  = we_q;
   assign cyc_m2s = act_q;
   assign stb_m2s = act_q;
   assign rdata   = rdata_q;

endmodule

// File: rtl/iwdg_wb_sequencer.sv
// -----------------------------------------------------------------------------
// iwdg_wb_sequencer
// Wishbone master that configures, starts and refreshes the IWDG. On an
// accepted cfg_start it runs: unlock, write PR, write RLR, read back RLR,
// reload, start, with one idle bus cycle after every transaction. Once
// running, each (coalesced) kick request becomes one reload-key write.
//
// Ports
//   clk_m2s, rst_m2s    bus clock, asynchronous active-high reset
//   cfg_start           pulse: run the configure sequence (IDLE or RUN only)
//   cfg_pr, cfg_rlr     prescaler / reload values, latched on accepted start
//   kick                pulse: request a watchdog refresh
//   adr_m2s .. stb_m2s  Wishbone master outputs
//   dat_s2m, ack_s2m    Wishbone slave response
//   busy                a configure step or kick transaction is in progress
//   running             watchdog started and refreshable
//   done                one-cycle pulse when the configure sequence completes
//   err                 sticky timeout / readback-mismatch flag
//   refresh_cnt         completed kick writes, wraps at 255
// -----------------------------------------------------------------------------
module iwdg_wb_sequencer
   import iwdg_pkg::*;
#(
   parameter int          IWDG_KR_SIZE  = 16,
   parameter int          IWDG_PR_SIZE  = 3,
   parameter int          IWDG_RLR_SIZE = 12,
   parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
   parameter logic [31:0] IWDG_KR_ADR   = BASE_ADR + KR_OFS,
   parameter logic [31:0] IWDG_PR_ADR   = BASE_ADR + PR_OFS,
   parameter logic [31:0] IWDG_RLR_ADR  = BASE_ADR + RLR_OFS,
   parameter int          ACK_TIMEOUT   = 16
) (
   input  logic                     clk_m2s,
   input  logic                     rst_m2s,
   input  logic                     cfg_start,
   input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
   input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
   input  logic                     kick,
   output logic [31:0]              adr_m2s,
   output logic [IWDG_KR_SIZE-1:0]  dat_m2s,
   output logic                     we_m2s,
   output logic                     cyc_m2s,
   output logic                     stb_m2s,
   input  logic [IWDG_KR_SIZE-1:0]  dat_s2m,
   input  logic                     ack_s2m,
   output logic                     busy,
   output logic                     running,
   output logic                     done,
   output logic                     err,
   output logic [7:0]               refresh_cnt
);

   iwdg_state_e              state_q,   state_d;
   iwdg_state_e              last_q,    last_d;     // bus state preceding GAP
   logic                     pending_q, pending_d;
   logic [IWDG_PR_SIZE-1:0]  cfg_pr_q,  cfg_pr_d;
   logic [IWDG_RLR_SIZE-1:0] cfg_rlr_q, cfg_rlr_d;
   logic                     err_q,     err_d;
   logic                     running_q, running_d;
   logic                     done_q,    done_d;
   logic                     busy_q,    busy_d;
   logic [7:0]               refresh_q, refresh_d;

   logic                     accept;
   logic                     launch;
   logic [31:0]              req_adr;
   logic [IWDG_KR_SIZE-1:0]  req_dat;
   logic                     req_we;
   logic                     xfer_done;
   logic                     xfer_timeout;
   logic [IWDG_KR_SIZE-1:0]  rdata;
   logic                     unused_rdata;

   // Only the low IWDG_RLR_SIZE bits of the readback take part in the check.
   assign unused_rdata = ^rdata;

   // ---------------------------------------------------------------- FSM ---
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      pending_d = pending_q;
      cfg_pr_d  = cfg_pr_q;
      cfg_rlr_d = cfg_rlr_q;
      err_d     = err_q;
      running_d = running_q;
      refresh_d = refresh_q;
      done_d    = 1'b0;

      accept = cfg_start && (state_q == ST_IDLE || state_q == ST_RUN);

      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (accept) begin
               // A new start wins over any pending kick.
               state_d   = ST_UNLOCK;
               cfg_pr_d  = cfg_pr;
               cfg_rlr_d = cfg_rlr;
               err_d     = 1'b0;
               running_d = 1'b0;
               refresh_d = '0;
               pending_d = 1'b0;
            end else if (state_q == ST_RUN && pending_q) begin
               state_d   = ST_KICK;
               pending_d = 1'b0;
            end
         end

         ST_GAP: begin
            if (last_q == ST_RD_RLR &&
                rdata[IWDG_RLR_SIZE-1:0] != cfg_rlr_q) begin
               // Readback disagrees: never reload or start the watchdog.
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = next_after(last_q);
               if (last_q == ST_START) begin
                  running_d = 1'b1;
                  done_d    = 1'b1;
               end
            end
         end

         default: begin  // bus states
            if (xfer_done) begin
               state_d = ST_GAP;
               last_d  = state_q;
               if (state_q == ST_KICK) refresh_d = refresh_q + 8'd1;
            end else if (xfer_timeout) begin
               state_d   = ST_IDLE;
               err_d     = 1'b1;
               running_d = 1'b0;
               pending_d = 1'b0;
            end
         end
      endcase

      // Kicks coalesce into a single pending flag; they mean nothing before
      // a sequence has been started, and an accepted start or abort drops them.
      if (kick && state_q != ST_IDLE && !accept && !xfer_timeout)
         pending_d = 1'b1;

      busy_d = !(state_d inside {ST_IDLE, ST_RUN});
   end

   // Request fields follow the state being entered, so the transaction
   // engine raises cyc/stb on the same edge as the FSM transition.
   always_comb begin
      req_adr = IWDG_KR_ADR;
      req_dat = '0;
      req_we  = 1'b1;
      case (state_d)
         ST_UNLOCK: req_dat = IWDG_KR_SIZE'(KEY_ACCESS);
         ST_WR_PR: begin
            req_adr = IWDG_PR_ADR;
            req_dat = IWDG_KR_SIZE'(cfg_pr_q);
         end
         ST_WR_RLR: begin
            req_adr = IWDG_RLR_ADR;
            req_dat = IWDG_KR_SIZE'(cfg_rlr_q);
         end
         ST_RD_RLR: begin
            req_adr = IWDG_RLR_ADR;
            req_we  = 1'b0;
         end
         ST_RELOAD, ST_KICK: req_dat = IWDG_KR_SIZE'(KEY_RELOAD);
         ST_START:           req_dat = IWDG_KR_SIZE'(KEY_START);
         default: ;
      endcase
      launch = is_bus_state(state_d) && (state_d != state_q);
   end

   always_ff @(posedge clk_m2s or posedge rst_m2s) begin
      if (rst_m2s) begin
         state_q   <= ST_IDLE;
         last_q    <= ST_IDLE;
         pending_q <= 1'b0;
         cfg_pr_q  <= '0;
         cfg_rlr_q <= '0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         refresh_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         pending_q <= pending_d;
         cfg_pr_q  <= cfg_pr_d;
         cfg_rlr_q <= cfg_rlr_d;
         err_q     <= err_d;
         running_q <= running_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         refresh_q <= refresh_d;
      end
   end

   // ------------------------------------------------- transaction engine ---
   iwdg_wb_xfer #(
      .DW      (IWDG_KR_SIZE),
      .TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .clk_m2s      (clk_m2s),
      .rst_m2s      (rst_m2s),
      .launch       (launch),
      .req_adr      (req_adr),
      .req_dat      (req_dat),
      .req_we       (req_we),
      .adr_m2s      (adr_m2s),
      .dat_m2s      (dat_m2s),
      .we_m2s       (we_m2s),
      .cyc_m2s      (cyc_m2s),
      .stb_m2s      (stb_m2s),
      .dat_s2m      (dat_s2m),
      .ack_s2m      (ack_s2m),
      .xfer_done    (xfer_done),
      .xfer_timeout (xfer_timeout),
      .rdata        (rdata)
   );

   assign busy        = busy_q;
   assign running     = running_q;
   assign done        = done_q;
   assign err         = err_q;
   assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_iwdg_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iwdg_wb_sequencer
// Self-checking bench: a Wishbone slave with programmable ack latency and
// readback value, a bus monitor that records every transaction (address,
// data, direction, acked, stb length, idle cycles before it), and a
// transaction-list reference model built from the configure-sequence rules.
// -----------------------------------------------------------------------------
module tb_iwdg_wb_sequencer;

   localparam logic [31:0] KR_A  = 32'h0100_0000;
   localparam logic [31:0] PR_A  = 32'h0100_0004;
   localparam logic [31:0] RLR_A = 32'h0100_0008;
   localparam int          TO    = 16;

   logic        clk_m2s = 1'b0;
   logic        rst_m2s;
   logic        cfg_start;
   logic [2:0]  cfg_pr;
   logic [11:0] cfg_rlr;
   logic        kick;
   logic [31:0] adr_m2s;
   logic [15:0] dat_m2s;
   logic        we_m2s, cyc_m2s, stb_m2s;
   logic [15:0] dat_s2m;
   logic        ack_s2m;
   logic        busy, running, done, err;
   logic [7:0]  refresh_cnt;

   iwdg_wb_sequencer dut (
      .clk_m2s     (clk_m2s),
      .rst_m2s     (rst_m2s),
      .cfg_start   (cfg_start),
      .cfg_pr      (cfg_pr),
      .cfg_rlr     (cfg_rlr),
      .kick        (kick),
      .adr_m2s     (adr_m2s),
      .dat_m2s     (dat_m2s),
      .we_m2s      (we_m2s),
      .cyc_m2s     (cyc_m2s),
      .stb_m2s     (stb_m2s),
      .dat_s2m     (dat_s2m),
      .ack_s2m     (ack_s2m),
      .busy        (busy),
      .running     (running),
      .done        (done),
      .err         (err),
      .refresh_cnt (refresh_cnt)
   );

   always #5 clk_m2s = ~clk_m2s;

   typedef struct {
      logic [31:0] adr;
      logic [15:0] dat;
      logic        we;
      bit          acked;
      int          len;
      int          gap;   // idle cycles before this transaction, -1 = any
   } txn_t;

   txn_t act_q[$];
   txn_t exp_q[$];

   int   n_cmp = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   busy_cyc = 0;

   int          ack_lat = 2;
   logic [15:0] rd_val = '0;
   bit          mute = 0;
   bit          spur_ack = 0;

   // ------------------------------------------------------------ slave ---
   // Decides ack for the current cycle just after each rising edge: ack comes
   // in the (ack_lat+1)-th cycle of stb.
   initial begin
      int wait_n;
      wait_n  = 0;
      ack_s2m = 1'b0;
      dat_s2m = '0;
      forever begin
         @(posedge clk_m2s);
         #1;
         if (cyc_m2s && stb_m2s && !mute) begin
            if (wait_n >= ack_lat) begin
               ack_s2m = 1'b1;
               dat_s2m = we_m2s ? 16'h0000 : rd_val;
               wait_n  = 0;
            end else begin
               ack_s2m = 1'b0;
               wait_n++;
            end
         end else begin
            ack_s2m = spur_ack && !stb_m2s;
            wait_n  = 0;
         end
      end
   end

   // ---------------------------------------------------------- monitor ---
   initial begin
      bit   prev;
      int   len, gap;
      txn_t cur;
      prev = 0;
      len  = 0;
      gap  = 0;
      cur  = '{adr: '0, dat: '0, we: 1'b0, acked: 0, len: 0, gap: 0};
      forever begin
         @(negedge clk_m2s);
         if (done) done_cnt++;
         if (busy) busy_cyc++;
         if (stb_m2s) begin
            if (!prev) begin
               cur.adr   = adr_m2s;
               cur.dat   = dat_m2s;
               cur.we    = we_m2s;
               cur.acked = 0;
               cur.gap   = gap;
               len       = 0;
            end
            len++;
            if (ack_s2m) cur.acked = 1;
         end else begin
            if (prev) begin
               cur.len = len;
               act_q.push_back(cur);
               gap = 0;
            end
            gap++;
         end
         prev = stb_m2s;
      end
   end

   // ---------------------------------------------------------- helpers ---
   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk_m2s);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      tick();
      while (busy && k < budget) begin
         tick();
         k++;
      end
      check({tag, " idle within budget"}, busy, 1'b0);
   endtask

   task automatic exp_push(input logic [31:0] adr, input logic [15:0] dat,
                           input logic we, input bit acked, input int len,
                           input int gap);
      txn_t t;
      t = '{adr: adr, dat: dat, we: we, acked: acked, len: len, gap: gap};
      exp_q.push_back(t);
   endtask

   // Reference model of the configure sequence: six transactions with one
   // idle cycle between them, truncated after the readback on a mismatch.
   task automatic model_config(input logic [2:0] pr, input logic [11:0] rlr,
                               input logic [11:0] rb, input int lat);
      exp_push(KR_A,  16'h5555,        1'b1, 1, lat + 1, -1);
      exp_push(PR_A,  {13'b0, pr},     1'b1, 1, lat + 1, 1);
      exp_push(RLR_A, {4'b0, rlr},     1'b1, 1, lat + 1, 1);
      exp_push(RLR_A, 16'h0000,        1'b0, 1, lat + 1, 1);
      if (rb == rlr) begin
         exp_push(KR_A, 16'hAAAA,      1'b1, 1, lat + 1, 1);
         exp_push(KR_A, 16'hCCCC,      1'b1, 1, lat + 1, 1);
      end
   endtask

   task automatic compare_txns(input string tag);
      check({tag, " txn count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d] adr", tag, i), act_q[i].adr, exp_q[i].adr);
         check($sformatf("%s[%0d] we", tag, i), act_q[i].we, exp_q[i].we);
         if (exp_q[i].we)
            check($sformatf("%s[%0d] dat", tag, i), act_q[i].dat, exp_q[i].dat);
         check($sformatf("%s[%0d] acked", tag, i), act_q[i].acked, exp_q[i].acked);
         check($sformatf("%s[%0d] stb len", tag, i), act_q[i].len, exp_q[i].len);
         if (exp_q[i].gap >= 0)
            check($sformatf("%s[%0d] gap", tag, i), act_q[i].gap, exp_q[i].gap);
      end
      act_q.delete();
      exp_q.delete();
   endtask

   // One-cycle cfg_start; the inputs are scrambled right after so the DUT
   // must have latched them.
   task automatic start_cfg(input logic [2:0] pr, input logic [11:0] rlr);
      cfg_pr    = pr;
      cfg_rlr   = rlr;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_pr    = 3'($urandom);
      cfg_rlr   = 12'($urandom);
   endtask

   task automatic run_config(input string tag, input logic [2:0] pr,
                             input logic [11:0] rlr, input logic [11:0] rb,
                             input int lat, input bit stray);
      int d0;
      bit ok;
      ok      = (rb == rlr);
      ack_lat = lat;
      rd_val  = {4'($urandom), rb};
      d0      = done_cnt;
      act_q.delete();
      model_config(pr, rlr, rb, lat);
      start_cfg(pr, rlr);
      check({tag, " err cleared on start"}, err, 1'b0);
      check({tag, " running cleared on start"}, running, 1'b0);
      if (stray) begin
         tick($urandom_range(1, 6));
         if (busy) start_cfg(3'($urandom), 12'($urandom));
      end
      wait_idle(tag, 200);
      tick();
      compare_txns(tag);
      check({tag, " err"}, err, !ok);
      check({tag, " running"}, running, ok);
      check({tag, " done pulses"}, done_cnt - d0, ok ? 1 : 0);
      check({tag, " refresh_cnt"}, refresh_cnt, 8'd0);
   endtask

   // -------------------------------------------------------- stimulus ---
   initial begin
      logic [2:0]  pr;
      logic [11:0] rlr, rb;
      int          lat, k;

      rst_m2s   = 1'b1;
      cfg_start = 1'b0;
      cfg_pr    = '0;
      cfg_rlr   = '0;
      kick      = 1'b0;
      tick(3);

      // Reset state.
      check("rst cyc", cyc_m2s, 1'b0);
      check("rst stb", stb_m2s, 1'b0);
      check("rst we", we_m2s, 1'b0);
      check("rst adr", adr_m2s, 32'h0);
      check("rst dat", dat_m2s, 16'h0);
      check("rst busy", busy, 1'b0);
      check("rst running", running, 1'b0);
      check("rst done", done, 1'b0);
      check("rst err", err, 1'b0);
      check("rst refresh", refresh_cnt, 8'd0);
      rst_m2s = 1'b0;
      tick(2);
      act_q.delete();

      // Directed configure, then readback mismatch.
      run_config("t1", 3'b001, 12'h001, 12'h001, 2, 0);
      run_config("t2", 3'b001, 12'h001, 12'h002, 2, 0);

      // Randomized configurations, latencies and readbacks, with stray
      // cfg_start pulses mid-sequence that must be ignored.
      for (int i = 0; i < 6; i++) begin
         pr  = 3'($urandom_range(0, 7));
         rlr = 12'($urandom_range(0, 4095));
         rb  = ($urandom_range(0, 2) == 0) ?
               (rlr ^ (12'h001 << $urandom_range(0, 11))) : rlr;
         lat = $urandom_range(0, 3);
         run_config($sformatf("rnd%0d", i), pr, rlr, rb, lat, 1);
      end

      // Single kick in RUN.
      run_config("t3cfg", 3'd4, 12'h3FF, 12'h3FF, 1, 0);
      busy_cyc = 0;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      wait_idle("t3", 50);
      tick();
      exp_push(KR_A, 16'hAAAA, 1'b1, 1, 2, -1);
      compare_txns("t3");
      check("t3 refresh_cnt", refresh_cnt, 8'd1);
      check("t3 busy cycles", busy_cyc, 3);
      check("t3 running", running, 1'b1);

      // Three kicks while a kick write awaits ack coalesce into one more.
      run_config("t4cfg", 3'd2, 12'hABC, 12'hABC, 1, 0);
      ack_lat = 5;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      k = 0;
      while (!stb_m2s && k < 10) begin
         tick();
         k++;
      end
      check("t4 kick launched", stb_m2s, 1'b1);
      kick = 1'b1;
      tick(3);
      kick = 1'b0;
      tick(40);
      exp_push(KR_A, 16'hAAAA, 1'b1, 1, 6, -1);
      exp_push(KR_A, 16'hAAAA, 1'b1, 1, 6, 2);
      compare_txns("t4");
      check("t4 refresh_cnt", refresh_cnt, 8'd2);
      check("t4 busy", busy, 1'b0);

      // Ack with no cycle open is ignored.
      spur_ack = 1;
      tick(2);
      spur_ack = 0;
      tick(3);
      check("spur txn count", act_q.size(), 0);
      check("spur refresh_cnt", refresh_cnt, 8'd2);
      check("spur busy", busy, 1'b0);
      check("spur running", running, 1'b1);

      // Slave never acks the unlock write: abort after TO cycles of stb.
      mute = 1;
      act_q.delete();
      start_cfg(3'd5, 12'h123);
      wait_idle("t5", 60);
      tick();
      exp_push(KR_A, 16'h5555, 1'b1, 0, TO, -1);
      compare_txns("t5");
      check("t5 err", err, 1'b1);
      check("t5 running", running, 1'b0);
      check("t5 busy", busy, 1'b0);
      check("t5 cyc", cyc_m2s, 1'b0);
      kick = 1'b1;
      tick();
      kick = 1'b0;
      tick(6);
      check("t5 kick in idle txns", act_q.size(), 0);
      check("t5 refresh_cnt", refresh_cnt, 8'd0);
      mute = 0;
      run_config("t5retry", 3'd5, 12'h123, 12'h123, 0, 0);

      // Reset in the middle of the RLR write.
      ack_lat = 3;
      act_q.delete();
      start_cfg(3'd6, 12'h456);
      k = 0;
      while (!(stb_m2s && we_m2s && adr_m2s == RLR_A) && k < 60) begin
         tick();
         k++;
      end
      check("t6 reached WR_RLR", stb_m2s && we_m2s && adr_m2s == RLR_A, 1'b1);
      #2;
      rst_m2s = 1'b1;
      #1;
      check("t6 cyc", cyc_m2s, 1'b0);
      check("t6 stb", stb_m2s, 1'b0);
      check("t6 we", we_m2s, 1'b0);
      check("t6 busy", busy, 1'b0);
      check("t6 running", running, 1'b0);
      tick();
      rst_m2s = 1'b0;
      tick(2);
      act_q.delete();
      busy_cyc = 0;
      kick = 1'b1;
      tick();
      kick = 1'b0;
      tick(10);
      check("t6 kick after reset txns", act_q.size(), 0);
      check("t6 busy cycles", busy_cyc, 0);
      check("t6 err", err, 1'b0);
      check("t6 refresh_cnt", refresh_cnt, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/iwdg_wb_sequencer.md
Name: iwdg_wb_sequencer

Overview:
Wishbone master that configures, starts and refreshes the IWDG slave. It runs the fixed sequence: unlock, program PR, program RLR, read back RLR, reload, start. Afterwards it issues reload-key writes on request. It sits between system control logic (start/kick strobes) and the IWDG Wishbone slave port, on the bus clock domain.

Parameters:
IWDG_KR_SIZE, 16, width of Wishbone data bus and key register
IWDG_PR_SIZE, 3, prescaler field width
IWDG_RLR_SIZE, 12, reload field width
BASE_ADR, 32'h0100_0000, IWDG base address
IWDG_KR_ADR / IWDG_PR_ADR / IWDG_RLR_ADR, BASE_ADR+0x0 / +0x4 / +0x8, register addresses
ACK_TIMEOUT, 16, cycles stb may stay unacked before abort (≥2)

Ports:
clk_m2s  in  1  bus clock
rst_m2s  in  1  asynchronous reset, active-high
cfg_start  in  1  pulse: start full configure sequence
cfg_pr  in  IWDG_PR_SIZE  prescaler value; sampled on accepted cfg_start
cfg_rlr  in  IWDG_RLR_SIZE  reload value; sampled on accepted cfg_start
kick  in  1  pulse: request watchdog refresh
adr_m2s  out  32  Wishbone address
dat_m2s  out  IWDG_KR_SIZE  Wishbone write data
we_m2s  out  1  Wishbone write enable
cyc_m2s  out  1  Wishbone cycle
stb_m2s  out  1  Wishbone strobe
dat_s2m  in  IWDG_KR_SIZE  Wishbone read data
ack_s2m  in  1  Wishbone acknowledge
busy  out  1  sequence or kick transaction in progress
running  out  1  watchdog started and refreshable
done  out  1  one-cycle pulse when configure sequence completes
err  out  1  sticky: timeout or readback mismatch; cleared by next accepted cfg_start
refresh_cnt  out  8  completed kick writes; wraps 255→0; cleared by accepted cfg_start

Behaviour:
- Reset: all outputs 0; state IDLE; pending-kick flag 0; cfg latches 0. Asserting reset mid-transaction drops cyc/stb immediately, with no completion.
- States: IDLE, UNLOCK, WR_PR, WR_RLR, RD_RLR, RELOAD, START, RUN, KICK, GAP.
- Bus states drive cyc=stb=1 and adr/dat/we from the registered transition edge. Values:
  - UNLOCK: KR, 16'h5555, we=1
  - WR_PR: PR, zero-extended cfg_pr, we=1
  - WR_RLR: RLR, zero-extended cfg_rlr, we=1
  - RD_RLR: RLR, we=0, dat_m2s don't-care
  - RELOAD: KR, 16'hAAAA, we=1
  - START: KR, 16'hCCCC, we=1
  - KICK: KR, 16'hAAAA, we=1
- Completion: on the edge where ack_s2m=1 is sampled, cyc/stb drop and the FSM enters GAP for exactly one cycle, then the next state. adr/dat/we hold their last values while idle.
- Sequence order: UNLOCK→WR_PR→WR_RLR→RD_RLR→RELOAD→START→RUN.
- RD_RLR: compare dat_s2m[IWDG_RLR_SIZE-1:0] to latched cfg_rlr on ack. Mismatch → err=1, go to IDLE; RELOAD/START are not issued.
- Entering RUN from START: running=1, done pulses in that same cycle.
- cfg_start accepted only in IDLE or RUN with no transaction active. It re-runs the whole sequence; running is cleared on accept and set again on completion. cfg_start at any other time is ignored.
- kick: ignored in IDLE (running=0). Otherwise it sets the pending flag. Multiple kicks before service coalesce into one.
- RUN with pending=1 → KICK (flag cleared on entry). On ack: refresh_cnt+1, then GAP→RUN.
- Simultaneous cfg_start and pending kick in RUN: cfg_start wins and the pending flag is cleared.
- Timeout: counter increments each cycle stb=1 and ack=0. At count == ACK_TIMEOUT, drop cyc/stb, err=1, running=0, pending=0, go to IDLE. The counter resets on every new transaction.
- busy = state ∉ {IDLE, RUN}.
- ack_s2m while cyc=0 is ignored.

Decomposition:
- Package iwdg_pkg: key constants KEY_ACCESS=16'h5555, KEY_RELOAD=16'hAAAA, KEY_START=16'hCCCC; register offsets; state enum.
- Sub-module iwdg_wb_xfer: single-transaction engine (launch, hold until ack, timeout counter, read-data capture, done/timeout pulses). The FSM in iwdg_wb_sequencer selects adr/dat/we for it.

Test Plan:
1. cfg_start, cfg_pr=3'b001, cfg_rlr=12'h001; slave acks 2 cycles after stb and returns RLR=12'h001 → bus writes KR 5555, PR 0001, RLR 0001, read RLR, KR AAAA, KR CCCC in that order, one idle cycle between each; done pulses once; running=1; err=0.
2. Same config but slave returns RLR=12'h002 → err=1, running=0; no AAAA/CCCC write appears; state IDLE.
3. In RUN, single kick → one write KR=AAAA; refresh_cnt=1; busy high only during KICK/GAP.
4. Three kicks while a KICK transaction is pending ack → exactly one further AAAA write; refresh_cnt=2.
5. Slave never acks on UNLOCK → cyc/stb drop after 16 cycles; err=1; busy=0; next cfg_start clears err and retries.
6. Assert rst_m2s mid-WR_RLR → cyc/stb/we/busy/running=0 asynchronously. After release, kick is ignored (no bus activity).
